// File: rtl/dac_spi_tx.sv
// dac_spi_tx: sample FIFO feeding a 16-bit SYNC/SCLK/DIN serial DAC framer (MSB first); in_ready = !full.
// Define DAC_SPI_TX_SIGNED_IN_EN to accept two's-complement samples (MSB flipped to offset binary on load).
module dac_spi_tx #(
  parameter int DATA_W     = 16,
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYC    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ena,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          in_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          sclk,
  output logic                          sync_n,
  output logic                          sdata,
  output logic                          busy,
  output logic                          underrun
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int BIT_W = $clog2(DATA_W) + 1;
  localparam int GAP_W = $clog2(GAP_CYC) + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP
  } state_e;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic [LVL_W-1:0]  level_d;
  logic              fifo_wr;
  logic              fifo_rd;
  logic              fifo_empty;
  logic              fifo_full;
  logic [DATA_W-1:0] head;

  state_e            state_q;
  logic [DATA_W-2:0] shreg_q;
  logic [DIV_W-1:0]  div_q;
  logic [BIT_W-1:0]  bit_q;
  logic [GAP_W-1:0]  gap_q;
  logic              sclk_q;
  logic              sync_n_q;
  logic              sdata_q;
  logic              underrun_q;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign fifo_wr    = in_valid && !fifo_full;
  assign fifo_rd    = (state_q == ST_LOAD) && !fifo_empty;

`ifdef DAC_SPI_TX_SIGNED_IN_EN
  assign head = mem_q[rd_ptr_q] ^ {1'b1, {(DATA_W-1){1'b0}}};
`else
  assign head = mem_q[rd_ptr_q];
`endif

  always_comb begin
    level_d = level_q;
    case ({fifo_wr, fifo_rd})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fifo_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  // sync_n and the MSB are registered on the edge entering LOAD; the pop into shreg happens on leaving it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      div_q      <= '0;
      bit_q      <= '0;
      gap_q      <= '0;
      sclk_q     <= 1'b1;
      sync_n_q   <= 1'b1;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ena && !fifo_empty) begin
            state_q  <= ST_LOAD;
            sync_n_q <= 1'b0;
            sclk_q   <= 1'b1;
            sdata_q  <= head[DATA_W-1];
          end
        end
        ST_LOAD: begin
          shreg_q <= head[DATA_W-2:0];
          div_q   <= '0;
          bit_q   <= '0;
          state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (div_q == DIV_W'(CLK_DIV - 1)) begin
            div_q <= '0;
            if (sclk_q) begin
              sclk_q <= 1'b0;
              bit_q  <= bit_q + 1'b1;
            end else begin
              sclk_q <= 1'b1;
              if (bit_q == BIT_W'(DATA_W)) begin
                sync_n_q <= 1'b1;
                sdata_q  <= 1'b0;
                gap_q    <= '0;
                state_q  <= ST_GAP;
              end else begin
                sdata_q <= shreg_q[DATA_W-2];
                shreg_q <= shreg_q << 1;
              end
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_q == GAP_W'(GAP_CYC)) begin
            if (ena && !fifo_empty) begin
              state_q  <= ST_LOAD;
              sync_n_q <= 1'b0;
              sdata_q  <= head[DATA_W-1];
            end else begin
              underrun_q <= underrun_q | ena;
              state_q    <= ST_IDLE;
            end
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = !fifo_full;
  assign fifo_level = level_q;
  assign sclk       = sclk_q;
  assign sync_n     = sync_n_q;
  assign sdata      = sdata_q;
  assign busy       = (state_q != ST_IDLE);
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx at default parameters; a monitor decodes DAC frames from the pins.
module tb_dac_spi_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic [2:0]  fifo_level;
  logic        sclk;
  logic        sync_n;
  logic        sdata;
  logic        busy;
  logic        underrun;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  dac_spi_tx dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .fifo_level (fifo_level),
    .sclk       (sclk),
    .sync_n     (sync_n),
    .sdata      (sdata),
    .busy       (busy),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame monitor: one record per sync_n low window.
  logic [15:0] fr_data [$];
  int          fr_len  [$];
  int          fr_start[$];
  int          fr_bits [$];
  logic [15:0] mon_sh = 16'h0;
  int          mon_nfall = 0;
  int          mon_fall_cyc = 0;
  logic        prev_sclk = 1'b1;
  logic        prev_sync = 1'b1;

  always @(negedge clk) begin
    if (prev_sync === 1'b1 && sync_n === 1'b0) begin
      mon_fall_cyc = cyc;
      mon_sh = 16'h0;
      mon_nfall = 0;
    end
    if (sync_n === 1'b0 && prev_sclk === 1'b1 && sclk === 1'b0) begin
      mon_sh = {mon_sh[14:0], sdata};
      mon_nfall++;
    end
    if (prev_sync === 1'b0 && sync_n === 1'b1) begin
      fr_data.push_back(mon_sh);
      fr_len.push_back(cyc - mon_fall_cyc);
      fr_start.push_back(mon_fall_cyc);
      fr_bits.push_back(mon_nfall);
    end
    prev_sclk = sclk;
    prev_sync = sync_n;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] conv(input logic [15:0] d);
`ifdef DAC_SPI_TX_SIGNED_IN_EN
    return d ^ 16'h8000;
`else
    return d;
`endif
  endfunction

  int base;
  int push_cyc;

  // All tasks start and end at negedge + 1.
  task automatic push(input logic [15:0] d, output logic acc);
    in_valid = 1'b1;
    in_data  = d;
    acc      = in_ready;
    push_cyc = cyc;
    @(negedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ena = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
    base = fr_data.size();
  endtask

  task automatic wait_frames(input int n, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if ((fr_data.size() - base) >= n && !busy) break;
      @(negedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  logic acc;
  logic [4:0] exp_acc;

  initial begin
    rst = 1'b1; ena = 1'b0; in_valid = 1'b0; in_data = 16'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_sclk", sclk, 1);
    chk("rst_sync_n", sync_n, 1);
    chk("rst_sdata", sdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    base = fr_data.size();

    // Single frame 0xA5C3
    ena = 1'b1;
    push(16'hA5C3, acc);
    chk("t1_accept", acc, 1);
    wait_frames(1, 400);
    chk("t1_frames", fr_data.size() - base, 1);
    if (fr_data.size() > base) begin
      chk("t1_data", fr_data[base], conv(16'hA5C3));
      chk("t1_bits", fr_bits[base], 16);
      chk("t1_low_len", fr_len[base], 129);
      chk("t1_fall_after_push", fr_start[base] - push_cyc, 2);
    end
    idle(4);
    chk("t1_busy_done", busy, 0);
    chk("t1_sync_idle", sync_n, 1);
    chk("t1_underrun", underrun, 1);

    // Five pushes with ena=0, then four back-to-back frames
    do_reset();
    chk("t2_underrun_cleared", underrun, 0);
    exp_acc = 5'b01111;
    for (int i = 0; i < 5; i++) begin
      push(16'h1111 * (i + 1), acc);
      chk($sformatf("t2_accept%0d", i), acc, exp_acc[i]);
    end
    chk("t2_level_full", fifo_level, 4);
    chk("t2_in_ready_full", in_ready, 0);
    chk("t2_idle_no_ena", busy, 0);
    ena = 1'b1;
    wait_frames(4, 1000);
    chk("t2_frames", fr_data.size() - base, 4);
    if (fr_data.size() >= base + 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("t2_data%0d", i), fr_data[base+i], conv(16'h1111 * (i + 1)));
        chk($sformatf("t2_len%0d", i), fr_len[base+i], 129);
      end
      for (int i = 0; i < 3; i++)
        chk($sformatf("t2_period%0d", i), fr_start[base+i+1] - fr_start[base+i], 132);
    end
    chk("t2_underrun", underrun, 1);
    chk("t2_level_empty", fifo_level, 0);

    // Empty FIFO with ena=1: nothing happens, no underrun
    do_reset();
    ena = 1'b1;
    idle(500);
    chk("t3_frames", fr_data.size() - base, 0);
    chk("t3_underrun", underrun, 0);
    chk("t3_busy", busy, 0);

    // Reset at the 7th falling sclk edge
    do_reset();
    push(16'h1234, acc);
    push(16'h7777, acc);
    ena = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (sync_n === 1'b0 && mon_nfall == 7) break;
      @(negedge clk); #1;
    end
    chk("t4_reached_fall7", mon_nfall, 7);
    chk("t4_level_mid", fifo_level, 1);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("t4_sync_n", sync_n, 1);
    chk("t4_sclk", sclk, 1);
    chk("t4_sdata", sdata, 0);
    chk("t4_level", fifo_level, 0);
    chk("t4_in_ready", in_ready, 1);
    chk("t4_busy", busy, 0);
    rst = 1'b0;
    base = fr_data.size();
    push(16'h0001, acc);
    wait_frames(1, 400);
    idle(300);
    chk("t4_frames", fr_data.size() - base, 1);
    if (fr_data.size() > base) begin
      chk("t4_data", fr_data[base], conv(16'h0001));
      chk("t4_bits", fr_bits[base], 16);
      chk("t4_low_len", fr_len[base], 129);
    end

    // Drop ena during bit 3 with two samples queued
    do_reset();
    push(16'h00FF, acc);
    push(16'h5A5A, acc);
    ena = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (sync_n === 1'b0 && mon_nfall == 3) break;
      @(negedge clk); #1;
    end
    chk("t5_reached_bit3", mon_nfall, 3);
    ena = 1'b0;
    wait_frames(1, 400);
    idle(300);
    chk("t5_frames", fr_data.size() - base, 1);
    if (fr_data.size() > base) begin
      chk("t5_data", fr_data[base], conv(16'h00FF));
      chk("t5_bits", fr_bits[base], 16);
      chk("t5_low_len", fr_len[base], 129);
    end
    chk("t5_level", fifo_level, 1);
    chk("t5_underrun", underrun, 0);
    chk("t5_busy", busy, 0);

    // Zero sample: offset-binary conversion shows up only with the signed option
    do_reset();
    ena = 1'b1;
    push(16'h0000, acc);
    wait_frames(1, 400);
    chk("t6_frames", fr_data.size() - base, 1);
    if (fr_data.size() > base) begin
`ifdef DAC_SPI_TX_SIGNED_IN_EN
      chk("t6_data", fr_data[base], 16'h8000);
`else
      chk("t6_data", fr_data[base], 16'h0000);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
